// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// magnitudes, one bit per cycle, with a final sign fix-up cycle before DONE.
module mdu_iter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_MOD   = 3'd5;
  localparam logic [2:0] OP_DIVU  = 3'd6;
  localparam logic [2:0] OP_MODU  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   src1_q, src1_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic                dz_q, dz_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic                is_signed;
  logic [DATA_W-1:0]   mag1, mag2;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_trial;

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic             n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] mul_fixup(input logic [2*DATA_W-1:0] p,
                                                  input logic               n,
                                                  input logic               hi_sel);
    logic [2*DATA_W-1:0] s;
    s = n ? (~p + 1'b1) : p;
    return hi_sel ? s[2*DATA_W-1:DATA_W] : s[DATA_W-1:0];
  endfunction

  // Divide-by-zero bypasses the sign fix-up: the raw restoring result is not meaningful there.
  function automatic logic [DATA_W-1:0] div_fixup(input logic [DATA_W-1:0] quo,
                                                  input logic [DATA_W-1:0] rem,
                                                  input logic              nq,
                                                  input logic              nr,
                                                  input logic              dz,
                                                  input logic              want_rem,
                                                  input logic [DATA_W-1:0] dividend);
    if (want_rem) return dz ? dividend : neg_if(rem, nr);
    return dz ? '1 : neg_if(quo, nq);
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    src1_d    = src1_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    dz_d      = dz_q;
    result_d  = result_q;

    is_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
    mag1      = neg_if(src1, is_signed & src1[DATA_W-1]);
    mag2      = neg_if(src2, is_signed & src2[DATA_W-1]);
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_trial = {hi_q, lo_q[DATA_W-1]} - {1'b0, a_q};

    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          state_d = CALC;
          cnt_d   = CNT_W'(DATA_W);
          op_d    = op;
          src1_d  = src1;
          hi_d    = '0;
          negq_d  = is_signed & (src1[DATA_W-1] ^ src2[DATA_W-1]);
          negr_d  = is_signed & src1[DATA_W-1];
          dz_d    = (src2 == '0);
          // Divide keeps the dividend in lo and divisor in a; multiply swaps roles.
          if (op[2]) begin
            lo_d = mag1;
            a_d  = mag2;
          end else begin
            lo_d = mag2;
            a_d  = mag1;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (op_q[2]) begin
            if (!div_trial[DATA_W]) {hi_d, lo_d} = {div_trial[DATA_W-1:0], lo_q[DATA_W-2:0], 1'b1};
            else                    {hi_d, lo_d} = {hi_q[DATA_W-2:0], lo_q, 1'b0};
          end else begin
            {hi_d, lo_d} = {mul_sum, lo_q[DATA_W-1:1]};
          end
        end else begin
          state_d = DONE;
          case (op_q)
            OP_MUL:   result_d = mul_fixup({hi_q, lo_q}, negq_q, 1'b0);
            OP_MULH,
            OP_MULHU: result_d = mul_fixup({hi_q, lo_q}, negq_q, 1'b1);
            OP_DIV,
            OP_DIVU:  result_d = div_fixup(lo_q, hi_q, negq_q, negr_q, dz_q, 1'b0, src1_q);
            OP_MOD,
            OP_MODU:  result_d = div_fixup(lo_q, hi_q, negq_q, negr_q, dz_q, 1'b1, src1_q);
            default:  result_d = '0;
          endcase
        end
      end
      DONE: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      src1_q   <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized and directed bench for mdu_iter against a 64-bit arithmetic reference model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_iter #(.DATA_W(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin up = ua * ub; return up[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; sp = sa / sb; return sp[31:0]; end
      3'd5: begin if (b == 0) return a; sp = sa % sb; return sp[31:0]; end
      3'd6: begin if (b == 0) return 32'hFFFFFFFF; up = ua / ub; return up[31:0]; end
      3'd7: begin if (b == 0) return a; up = ua % ub; return up[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Present a request at a negedge; returns just after the accepting edge.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("start_rdy", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 3'($urandom);
    src1     = $urandom;
    src2     = $urandom;
  endtask

  task automatic wait_valid(input string tag, output int lat);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 100);
    if (!out_valid) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      lat = -1;
    end else begin
      lat = k - 1;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e);
    int lat;
    start_op(o, a, b);
    wait_valid(tag, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk(tag, 64'(result), 64'(e));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_hs_ov"}, 64'(out_valid), 64'd0);
    chk({tag, "_hs_rdy"}, 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n_ov;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    resetn    = 1'b0;
    in_valid  = 1'b0;
    op        = 3'd0;
    src1      = 32'd0;
    src2      = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_res", 64'(result), 64'd0);
    resetn = 1'b1;

    do_op("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    do_op("mulh_mn", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
    do_op("mulhu_ff", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    do_op("mulh_m1", 3'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF);
    do_op("div_s", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    do_op("mod_s", 3'd5, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    do_op("divu", 3'd6, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC);
    do_op("modu", 3'd7, 32'hFFFFFFF9, 32'd2, 32'd1);
    do_op("div_nd", 3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
    do_op("mod_nd", 3'd5, 32'd7, 32'hFFFFFFFE, 32'd1);
    do_op("div_z", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF);
    do_op("modu_z", 3'd7, 32'd5, 32'd0, 32'd5);
    do_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    do_op("mod_ovf", 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    do_op("rsvd", 3'd3, 32'h12345678, 32'h9ABCDEF0, 32'd0);

    // Backpressure: result must hold while out_ready is low and inputs churn.
    start_op(3'd6, 32'hFFFFFFF9, 32'd2);
    wait_valid("bp", lat);
    chk("bp_lat", 64'(lat), 64'd33);
    repeat (5) begin
      @(posedge clk);
      #1;
      src1 = $urandom;
      src2 = $urandom;
      @(negedge clk);
      chk("bp_res", 64'(result), 64'h7FFFFFFC);
      chk("bp_ov", 64'(out_valid), 64'd1);
      chk("bp_rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drop", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Flush in the middle of CALC.
    start_op(3'd0, $urandom, $urandom);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl_rdy", 64'(in_ready), 64'd1);
    chk("fl_busy", 64'(busy), 64'd0);
    n_ov = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) n_ov++;
    end
    chk("fl_noval", 64'(n_ov), 64'd0);

    // Flush together with a request in IDLE: not accepted.
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    op       = 3'd0;
    src1     = 32'd3;
    src2     = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("fi_rdy", 64'(in_ready), 64'd1);
    chk("fi_busy", 64'(busy), 64'd0);

    // Asynchronous reset between edges in the middle of CALC.
    start_op(3'd4, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_ov", 64'(out_valid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_rdy", 64'(in_ready), 64'd1);
    chk("ar_res", 64'(result), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    n_ov = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) n_ov++;
    end
    chk("ar_noval", 64'(n_ov), 64'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = rnd_val();
      rb = rnd_val();
      do_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, ref_mdu(ro, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
